// File: rtl/sys_bus_fabric_if.sv
// CPU-side and slave-side signal bundle for sys_bus_fabric.
interface sys_bus_fabric_if #(
  parameter int AW       = 32,
  parameter int N_SLAVES = 4
);
  logic [AW-1:0]          m_addr;
  logic [31:0]            m_wdata;
  logic                   m_read;
  logic [1:0]             m_write;
  logic [31:0]            m_rdata;
  logic                   m_ready;
  logic                   m_err;
  logic [AW-1:0]          err_addr;

  logic [N_SLAVES-1:0]    s_sel;
  logic [AW-1:0]          s_addr;
  logic [31:0]            s_wdata;
  logic                   s_read;
  logic                   s_we;
  logic [3:0]             s_be;
  logic [N_SLAVES*32-1:0] s_rdata;
  logic [N_SLAVES-1:0]    s_ready;

  modport fabric (
    input  m_addr, m_wdata, m_read, m_write,
    output m_rdata, m_ready, m_err, err_addr,
    output s_sel, s_addr, s_wdata, s_read, s_we, s_be,
    input  s_rdata, s_ready
  );

  modport master (
    output m_addr, m_wdata, m_read, m_write,
    input  m_rdata, m_ready, m_err, err_addr
  );

  modport slave (
    input  s_sel, s_addr, s_wdata, s_read, s_we, s_be,
    output s_rdata, s_ready
  );
endinterface

// File: rtl/sys_bus_fabric.sv
// Single-master, N-slave bus fabric: registered request, address decode, byte enables, ready wait.
// Optional ACCESS wait timeout enabled by defining BUS_TIMEOUT_EN.
module sys_bus_fabric #(
  parameter int          AW       = 32,
  parameter int          N_SLAVES = 4,
  parameter int          SEL_BITS = 2,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic              clk,
  input logic              rst,
  sys_bus_fabric_if.fabric bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [SEL_BITS:0] IDX_LIMIT = (SEL_BITS + 1)'(N_SLAVES);

  if ((1 << SEL_BITS) < N_SLAVES || TIMEOUT < 2) begin : g_bad_cfg
    $error("sys_bus_fabric: invalid parameter combination");
  end

  logic [1:0]          state_q, state_d;
  logic [N_SLAVES-1:0] sel_q, sel_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       err_addr_q, err_addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                read_q, read_d;
  logic                we_q, we_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [3:0]          be_q, be_d;

`ifdef BUS_TIMEOUT_EN
  localparam int             CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic                req_vld;
  logic                req_wr;
  logic [1:0]          req_size;
  logic [SEL_BITS-1:0] req_idx;
  logic                dec_err;
  logic                mis_err;
  logic [3:0]          req_be;
  logic [31:0]         req_wdata;
  logic                slv_rdy;
  logic [31:0]         slv_rdata;

  // A write takes precedence over a simultaneous read; reads are always word-sized.
  always_comb begin
    req_wr   = (bus.m_write != 2'b00);
    req_vld  = req_wr | bus.m_read;
    req_size = req_wr ? bus.m_write : 2'b11;
    req_idx  = bus.m_addr[AW-1 -: SEL_BITS];
    dec_err  = ({1'b0, req_idx} >= IDX_LIMIT);
    mis_err  = ((req_size == 2'b10) && bus.m_addr[0]) ||
               ((req_size == 2'b11) && (bus.m_addr[1:0] != 2'b00));
    case (req_size)
      2'b01: begin
        req_be    = 4'b0001 << bus.m_addr[1:0];
        req_wdata = {4{bus.m_wdata[7:0]}};
      end
      2'b10: begin
        req_be    = 4'b0011 << bus.m_addr[1:0];
        req_wdata = {2{bus.m_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = bus.m_wdata;
      end
    endcase
  end

  always_comb begin
    slv_rdy   = |(bus.s_ready & sel_q);
    slv_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) slv_rdata = bus.s_rdata[i*32 +: 32];
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    read_d     = read_q;
    we_d       = we_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          if (dec_err || mis_err) begin
            state_d    = ST_RESP;
            ready_d    = 1'b1;
            err_d      = 1'b1;
            rdata_d    = ERR_DATA;
            err_addr_d = bus.m_addr;
          end else begin
            state_d = ST_ACCESS;
            sel_d   = N_SLAVES'(1) << req_idx;
            addr_d  = bus.m_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            read_d  = ~req_wr;
            we_d    = req_wr;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (slv_rdy) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          rdata_d = read_q ? slv_rdata : 32'h0;
          sel_d   = '0;
          read_d  = 1'b0;
          we_d    = 1'b0;
        end
`ifdef BUS_TIMEOUT_EN
        // A ready in the final counted cycle is taken by the branch above.
        else if (cnt_q == CNT_MAX) begin
          state_d    = ST_RESP;
          ready_d    = 1'b1;
          err_d      = 1'b1;
          rdata_d    = ERR_DATA;
          err_addr_d = addr_q;
          sel_d      = '0;
          read_d     = 1'b0;
          we_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      read_q     <= read_d;
      we_q       <= we_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.m_rdata  = rdata_q;
  assign bus.m_ready  = ready_q;
  assign bus.m_err    = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_read   = read_q;
  assign bus.s_we     = we_q;
  assign bus.s_be     = be_q;

endmodule
